// File: rtl/fringe_counter_pkg.sv
// rtl/fringe_counter_pkg.sv - shared types and quadrature decode for fringe_counter
package fringe_counter_pkg;

    localparam int CH_WIDTH = 16;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_ERR
    } dir_e;

    // Maps the {a,b} Gray code 00,10,11,01 onto phase 0,1,2,3.
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    function automatic dir_e quad_decode(input logic [1:0] prev, input logic [1:0] next);
        logic [1:0] step;
        step = quad_phase(next) - quad_phase(prev);
        case (step)
            2'd0:    return DIR_NONE;
            2'd1:    return DIR_UP;
            2'd3:    return DIR_DOWN;
            default: return DIR_ERR;
        endcase
    endfunction

endpackage

// File: rtl/schmitt_trigger.sv
// rtl/schmitt_trigger.sv - signed comparator with hysteresis hold for one channel
module schmitt_trigger
    import fringe_counter_pkg::*;
#(
    parameter int WIDTH = CH_WIDTH
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] lower,
    input  logic signed [WIDTH-1:0] upper,
    output logic                    out
);

    logic state;
    logic next_state;

    // out is the level this sample resolves to, so the decoder sees it on the same accept.
    always_comb begin
        next_state = state;
        if (upper > lower) begin
            if (sample > upper)
                next_state = 1'b1;
            else if (sample < lower)
                next_state = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= 1'b0;
        else if (enable)
            state <= next_state;
    end

    assign out = next_state;

endmodule

// File: rtl/fringe_counter.sv
// rtl/fringe_counter.sv - Schmitt-triggered quadrature fringe position counter with decimated AXI-Stream output
module fringe_counter
    import fringe_counter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ERR_WIDTH        = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
    input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
    input  logic [4:0]                    FC_log_decimation,
    input  logic                          FC_clear,
    output logic [ERR_WIDTH-1:0]          FC_error_count,
    input  logic                          S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
    input  logic                          M_AXIS_tready
);

    localparam int CW = AXIS_TDATA_WIDTH / 2;

    logic                        accept;
    logic                        emit;
    logic                        primed;
    logic                        err_inc;
    logic [1:0]                  prev_ab;
    logic [1:0]                  next_ab;
    logic [AXIS_TDATA_WIDTH-1:0] position;
    logic [AXIS_TDATA_WIDTH-1:0] pos_next;
    logic [31:0]                 dec_count;
    logic [31:0]                 dec_limit;
    dir_e                        dir;

    assign S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready;
    assign accept        = S_AXIS_tvalid & S_AXIS_tready;

    schmitt_trigger #(.WIDTH(CW)) u_schmitt_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (accept),
        .sample  (S_AXIS_tdata[CW-1:0]),
        .lower   (FC_lower_threshold),
        .upper   (FC_upper_threshold),
        .out     (next_ab[1])
    );

    schmitt_trigger #(.WIDTH(CW)) u_schmitt_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (accept),
        .sample  (S_AXIS_tdata[AXIS_TDATA_WIDTH-1:CW]),
        .lower   (FC_lower_threshold),
        .upper   (FC_upper_threshold),
        .out     (next_ab[0])
    );

    assign dir = quad_decode(prev_ab, next_ab);

    always_comb begin
        pos_next = position;
        err_inc  = 1'b0;
        if (primed) begin
            case (dir)
                DIR_UP:   pos_next = position + AXIS_TDATA_WIDTH'(1);
                DIR_DOWN: pos_next = position - AXIS_TDATA_WIDTH'(1);
                DIR_ERR:  err_inc  = 1'b1;
                default:  pos_next = position;
            endcase
        end
    end

    assign dec_limit = (32'd1 << FC_log_decimation) - 32'd1;
    assign emit      = accept & ~FC_clear & (dec_count >= dec_limit);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_ab        <= 2'b00;
            primed         <= 1'b0;
            position       <= '0;
            dec_count      <= '0;
            FC_error_count <= '0;
            M_AXIS_tvalid  <= 1'b0;
            M_AXIS_tdata   <= '0;
        end else begin
            if (accept)
                prev_ab <= next_ab;

            // Clear beats a coincident accept for counting state; the Schmitt bits still follow the sample.
            if (FC_clear) begin
                position       <= '0;
                FC_error_count <= '0;
                dec_count      <= '0;
                primed         <= 1'b0;
            end else if (accept) begin
                position  <= pos_next;
                primed    <= 1'b1;
                dec_count <= emit ? 32'd0 : dec_count + 32'd1;
                if (err_inc && (FC_error_count != {ERR_WIDTH{1'b1}}))
                    FC_error_count <= FC_error_count + ERR_WIDTH'(1);
            end

            if (emit) begin
                M_AXIS_tdata  <= pos_next;
                M_AXIS_tvalid <= 1'b1;
            end else if (M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fringe_counter.sv
// tb/tb_fringe_counter.sv - directed self-checking bench for fringe_counter
module tb_fringe_counter;

    logic        aclk;
    logic        aresetn;
    logic [15:0] FC_lower_threshold;
    logic [15:0] FC_upper_threshold;
    logic [4:0]  FC_log_decimation;
    logic        FC_clear;
    logic [15:0] FC_error_count;
    logic        S_AXIS_tvalid;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tready;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tready;

    int checks = 0;
    int errors = 0;

    fringe_counter #(.AXIS_TDATA_WIDTH(32), .ERR_WIDTH(16)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .FC_lower_threshold (FC_lower_threshold),
        .FC_upper_threshold (FC_upper_threshold),
        .FC_log_decimation  (FC_log_decimation),
        .FC_clear           (FC_clear),
        .FC_error_count     (FC_error_count),
        .S_AXIS_tvalid      (S_AXIS_tvalid),
        .S_AXIS_tdata       (S_AXIS_tdata),
        .S_AXIS_tready      (S_AXIS_tready),
        .M_AXIS_tvalid      (M_AXIS_tvalid),
        .M_AXIS_tdata       (M_AXIS_tdata),
        .M_AXIS_tready      (M_AXIS_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Forward Gray phase k: {a,b} = 00,10,11,01
    function automatic int pa(input int k);
        return ((k % 4) == 1 || (k % 4) == 2) ? 2000 : -2000;
    endfunction

    function automatic int pb(input int k);
        return ((k % 4) >= 2) ? 2000 : -2000;
    endfunction

    task automatic send(input int a, input int b);
        int waitc;
        @(negedge aclk);
        S_AXIS_tdata  = {16'(b), 16'(a)};
        S_AXIS_tvalid = 1'b1;
        waitc = 0;
        while (!S_AXIS_tready && waitc < 50) begin
            @(negedge aclk);
            waitc++;
        end
        if (!S_AXIS_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: S_AXIS_tready=%b want 1", S_AXIS_tready);
        end
        @(posedge aclk);
        #1 S_AXIS_tvalid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge aclk);
        FC_clear = 1'b1;
        @(negedge aclk);
        FC_clear = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #3;
        checks++;
        if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'd0 || FC_error_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b tdata=%h err=%0d want 0/0/0", M_AXIS_tvalid, M_AXIS_tdata, FC_error_count);
        end
        checks++;
        if (S_AXIS_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b want 1", S_AXIS_tready);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        send(2000, 2000);
        checks++;
        if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd0 || FC_error_count !== 16'd0) begin
            errors++;
            $display("FAIL prime_beat: tvalid=%b tdata=%h err=%0d want 1/0/0", M_AXIS_tvalid, M_AXIS_tdata, FC_error_count);
        end
    endtask

    task automatic test_forward();
        int fa [8];
        int fb [8];
        int fe [8];
        fa = '{2000, 2000, -2000, -2000, -2000, 2000, 2000, -2000};
        fb = '{-2000, 2000, 2000, -2000, 2000, 2000, -2000, -2000};
        fe = '{1, 2, 3, 4, 3, 2, 1, 0};
        pulse_clear();
        send(-2000, -2000);
        checks++;
        if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd0) begin
            errors++;
            $display("FAIL fwd_prime: tvalid=%b tdata=%h want 1/0", M_AXIS_tvalid, M_AXIS_tdata);
        end
        for (int i = 0; i < 8; i++) begin
            send(fa[i], fb[i]);
            checks++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'(fe[i])) begin
                errors++;
                $display("FAIL fwd_step%0d: tvalid=%b tdata=%h want 1/%h", i, M_AXIS_tvalid, M_AXIS_tdata, 32'(fe[i]));
            end
        end
    endtask

    task automatic test_hysteresis();
        int ha [6];
        ha = '{500, -500, 500, -500, 1000, -1000};
        for (int i = 0; i < 6; i++) begin
            send(ha[i], -2000);
            checks++;
            if (M_AXIS_tdata !== 32'd0) begin
                errors++;
                $display("FAIL hyst_%0d: tdata=%h want 0", i, M_AXIS_tdata);
            end
        end
        send(2000, -2000);
        checks++;
        if (M_AXIS_tdata !== 32'd1) begin
            errors++;
            $display("FAIL hyst_cross: tdata=%h want 1", M_AXIS_tdata);
        end
        FC_lower_threshold = 16'h7FFF;
        FC_upper_threshold = 16'h8000;
        send(-30000, -30000);
        send(30000, 30000);
        send(-30000, 30000);
        checks++;
        if (M_AXIS_tdata !== 32'd1 || FC_error_count !== 16'd0) begin
            errors++;
            $display("FAIL bad_thresh: tdata=%h err=%0d want 1/0", M_AXIS_tdata, FC_error_count);
        end
        FC_lower_threshold = -16'sd1000;
        FC_upper_threshold = 16'sd1000;
    endtask

    task automatic test_error_wrap();
        send(-2000, 2000);
        checks++;
        if (M_AXIS_tdata !== 32'd1 || FC_error_count !== 16'd1) begin
            errors++;
            $display("FAIL err_jump: tdata=%h err=%0d want 1/1", M_AXIS_tdata, FC_error_count);
        end
        @(negedge aclk);
        force dut.position = 32'h7FFF_FFFF;
        @(negedge aclk);
        release dut.position;
        send(-2000, -2000);
        checks++;
        if (M_AXIS_tdata !== 32'h8000_0000) begin
            errors++;
            $display("FAIL wrap_up: tdata=%h want 80000000", M_AXIS_tdata);
        end
        send(-2000, 2000);
        checks++;
        if (M_AXIS_tdata !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_down: tdata=%h want 7fffffff", M_AXIS_tdata);
        end
    endtask

    task automatic test_decimation();
        pulse_clear();
        FC_log_decimation = 5'd0;
        send(pa(0), pb(0));
        @(negedge aclk);
        FC_log_decimation = 5'd2;
        for (int k = 1; k <= 4; k++) begin
            send(pa(k), pb(k));
            if (k == 3) begin
                checks++;
                if (M_AXIS_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL dec_quiet: tvalid=%b want 0", M_AXIS_tvalid);
                end
            end
        end
        checks++;
        if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd4) begin
            errors++;
            $display("FAIL dec_beat4: tvalid=%b tdata=%h want 1/4", M_AXIS_tvalid, M_AXIS_tdata);
        end
        @(negedge aclk);
        M_AXIS_tready = 1'b0;
        S_AXIS_tdata  = {16'(pb(5)), 16'(pa(5))};
        S_AXIS_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checks++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd4 || S_AXIS_tready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: tvalid=%b tdata=%h s_tready=%b want 1/4/0", c, M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready);
            end
        end
        M_AXIS_tready = 1'b1;
        @(posedge aclk);
        #1 S_AXIS_tvalid = 1'b0;
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL release_drop: tvalid=%b want 0", M_AXIS_tvalid);
        end
        for (int k = 6; k <= 12; k++) begin
            send(pa(k), pb(k));
            if (k == 8 || k == 12) begin
                checks++;
                if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'(k)) begin
                    errors++;
                    $display("FAIL dec_beat%0d: tvalid=%b tdata=%h want 1/%h", k, M_AXIS_tvalid, M_AXIS_tdata, 32'(k));
                end
            end
        end
    endtask

    task automatic test_clear_reset();
        FC_log_decimation = 5'd0;
        send(pa(1), pb(1));
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: tvalid=%b tdata=%h want 0/0", M_AXIS_tvalid, M_AXIS_tdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        send(-2000, -2000);
        send(2000, 2000);
        checks++;
        if (M_AXIS_tdata !== 32'd0 || FC_error_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_err: tdata=%h err=%0d want 0/1", M_AXIS_tdata, FC_error_count);
        end
        send(-2000, 2000);
        checks++;
        if (M_AXIS_tdata !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_up: tdata=%h want 1", M_AXIS_tdata);
        end
        FC_clear = 1'b1;
        send(-2000, -2000);
        FC_clear = 1'b0;
        checks++;
        if (M_AXIS_tvalid !== 1'b0 || FC_error_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_accept: tvalid=%b err=%0d want 0/0", M_AXIS_tvalid, FC_error_count);
        end
        send(2000, -2000);
        checks++;
        if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd0) begin
            errors++;
            $display("FAIL clear_reprime: tvalid=%b tdata=%h want 1/0", M_AXIS_tvalid, M_AXIS_tdata);
        end
        send(2000, 2000);
        checks++;
        if (M_AXIS_tdata !== 32'd1 || FC_error_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_count: tdata=%h err=%0d want 1/0", M_AXIS_tdata, FC_error_count);
        end
    endtask

    initial begin
        aresetn            = 1'b0;
        S_AXIS_tvalid      = 1'b0;
        S_AXIS_tdata       = 32'd0;
        M_AXIS_tready      = 1'b1;
        FC_clear           = 1'b0;
        FC_lower_threshold = -16'sd1000;
        FC_upper_threshold = 16'sd1000;
        FC_log_decimation  = 5'd0;
        test_reset();
        test_forward();
        test_hysteresis();
        test_error_wrap();
        test_decimation();
        test_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
